// File: rtl/prci_tl_arbiter.sv
// Two-client round-robin arbiter in front of a PRCI TileLink acquire/grant port.
// An order FIFO of source ids sends each in-order grant back to the client that issued the matching acquire.
module prci_tl_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             c0_acq_valid,
    output logic                             c0_acq_ready,
    input  logic [110:0]                     c0_acq_bits,
    input  logic                             c1_acq_valid,
    output logic                             c1_acq_ready,
    input  logic [110:0]                     c1_acq_bits,
    output logic                             m_acq_valid,
    input  logic                             m_acq_ready,
    output logic [110:0]                     m_acq_bits,
    input  logic                             m_gnt_valid,
    output logic                             m_gnt_ready,
    input  logic [74:0]                      m_gnt_bits,
    output logic                             c0_gnt_valid,
    input  logic                             c0_gnt_ready,
    output logic [74:0]                      c0_gnt_bits,
    output logic                             c1_gnt_valid,
    input  logic                             c1_gnt_ready,
    output logic [74:0]                      c1_gnt_bits,
    output logic [$clog2(OUTSTANDING):0]     outstanding,
    output logic                             err
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);

    logic            rr;
    logic            lock;
    logic            lock_sel;
    logic            win;
    logic            win_valid;
    logic            full;
    logic            empty;
    logic            head;
    logic            push;
    logic            pop;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            order_mem [OUTSTANDING];

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = order_mem[rptr];

    // A stalled winner stays locked so the presented beat never changes under backpressure.
    always_comb begin
        win = 1'b0;
        if (lock)
            win = lock_sel;
        else if (c0_acq_valid && c1_acq_valid)
            win = rr;
        else
            win = c1_acq_valid;
    end

    assign win_valid    = win ? c1_acq_valid : c0_acq_valid;
    assign m_acq_valid  = win_valid && !full;
    assign m_acq_bits   = win ? c1_acq_bits : c0_acq_bits;
    assign c0_acq_ready = !win && !full && m_acq_ready;
    assign c1_acq_ready =  win && !full && m_acq_ready;

    assign c0_gnt_valid = m_gnt_valid && !empty && !head;
    assign c1_gnt_valid = m_gnt_valid && !empty &&  head;
    assign m_gnt_ready  = !empty && (head ? c1_gnt_ready : c0_gnt_ready);
    assign c0_gnt_bits  = m_gnt_bits;
    assign c1_gnt_bits  = m_gnt_bits;

    assign push = m_acq_valid && m_acq_ready;
    assign pop  = m_gnt_valid && m_gnt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr       <= 1'b0;
            lock     <= 1'b0;
            lock_sel <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            if (push) begin
                rr   <= !win;
                lock <= 1'b0;
                wptr <= wptr + PW'(1);
            end else if (m_acq_valid) begin
                lock     <= 1'b1;
                lock_sel <= win;
            end
            if (pop)
                rptr <= rptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (m_gnt_valid && empty)
                err <= 1'b1;
        end
    end

    // Entries need no reset: the count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            order_mem[wptr] <= win;
    end

    assign outstanding = count;
endmodule
